// File: rtl/ram_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter_if
// Purpose  : Requester-side bundle for one port of the RAM arbiter.
//            Carries the req/gnt handshake, the operation fields and the
//            read-data return path.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_rr_arbiter_if #(
    parameter int DW = 4,
    parameter int AW = 2
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    // Client logic drives the request side
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // The arbiter answers with grant and read data
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer in front of a single-port
//            synchronous RAM. Clears the RAM to INIT_VAL after reset, then
//            serves one read or write at a time. Writes occupy 2 cycles,
//            reads 3 cycles with rvalid two cycles after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter #(
    parameter int            DW       = 4,
    parameter int            AW       = 2,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ram_rr_arbiter_if.slave    port0,
    ram_rr_arbiter_if.slave    port1,
    output logic               init_done,
    output logic [AW-1:0]      mem_address,
    output logic               mem_WE,
    output logic [DW-1:0]      mem_data_in,
    input  wire logic [DW-1:0] mem_data_out
);

    // Counter is one bit wider than the address so it can reach DEPTH
    // and stop there instead of wrapping.
    localparam int            c_CW    = AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(1 << AW);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [c_CW-1:0] r_cnt,     w_cnt_nxt;
    logic            r_last,    w_last_nxt;   // port granted most recently
    logic            r_owner,   w_owner_nxt;  // port owning the op in flight
    logic            r_op_we,   w_op_we_nxt;  // op in flight is a write

    logic            r_gnt0,    w_gnt0;
    logic            r_gnt1,    w_gnt1;
    logic            r_rvalid0, w_rvalid0;
    logic            r_rvalid1, w_rvalid1;
    logic [DW-1:0]   r_rdata0,  w_rdata0;
    logic [DW-1:0]   r_rdata1,  w_rdata1;
    logic            r_we,      w_we;
    logic [AW-1:0]   r_addr,    w_addr;
    logic [DW-1:0]   r_din,     w_din;
    logic            r_init_done, w_init_done;

    logic            w_any_req;
    logic            w_pick1;

    // Round-robin choice: port 1 wins if alone, or on a tie when port 0 went last
    always_comb begin
        w_any_req = port0.req | port1.req;
        w_pick1   = port1.req & (~port0.req | ~r_last);
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_op_we_nxt = r_op_we;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_rvalid0   = 1'b0;
        w_rvalid1   = 1'b0;
        w_rdata0    = r_rdata0;
        w_rdata1    = r_rdata1;
        w_we        = 1'b0;
        w_addr      = r_addr;
        w_din       = r_din;
        w_init_done = r_init_done;

        case (r_state)
            ST_INIT: begin
                if (r_cnt < c_DEPTH) begin
                    w_we      = 1'b1;
                    w_addr    = r_cnt[AW-1:0];
                    w_din     = INIT_VAL;
                    w_cnt_nxt = r_cnt + c_ONE;
                end else begin
                    w_init_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (w_any_req) begin
                    if (w_pick1) begin
                        w_gnt1      = 1'b1;
                        w_we        = port1.we;
                        w_addr      = port1.addr;
                        w_din       = port1.wdata;
                        w_op_we_nxt = port1.we;
                        w_last_nxt  = 1'b1;
                        w_owner_nxt = 1'b1;
                    end else begin
                        w_gnt0      = 1'b1;
                        w_we        = port0.we;
                        w_addr      = port0.addr;
                        w_din       = port0.wdata;
                        w_op_we_nxt = port0.we;
                        w_last_nxt  = 1'b0;
                        w_owner_nxt = 1'b0;
                    end
                    w_state_nxt = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // RAM samples the op at the end of this cycle
                w_state_nxt = r_op_we ? ST_IDLE : ST_RESP;
            end

            ST_RESP: begin
                if (r_owner) begin
                    w_rvalid1 = 1'b1;
                    w_rdata1  = mem_data_out;
                end else begin
                    w_rvalid0 = 1'b1;
                    w_rdata0  = mem_data_out;
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State and sequencing registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_op_we <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
            r_op_we <= w_op_we_nxt;
        end
    end

    // Registered outputs toward requesters and RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_gnt0      <= w_gnt0;
            r_gnt1      <= w_gnt1;
            r_rvalid0   <= w_rvalid0;
            r_rvalid1   <= w_rvalid1;
            r_rdata0    <= w_rdata0;
            r_rdata1    <= w_rdata1;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_din       <= w_din;
            r_init_done <= w_init_done;
        end
    end

    assign port0.gnt    = r_gnt0;
    assign port0.rvalid = r_rvalid0;
    assign port0.rdata  = r_rdata0;
    assign port1.gnt    = r_gnt1;
    assign port1.rvalid = r_rvalid1;
    assign port1.rdata  = r_rdata1;
    assign init_done    = r_init_done;
    assign mem_address  = r_addr;
    assign mem_WE       = r_we;
    assign mem_data_in  = r_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rr_arbiter
// Purpose  : Self-checking bench for ram_rr_arbiter with a behavioural RAM,
//            a transaction-level reference model, directed scenarios and a
//            randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_rr_arbiter;
    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT = 4'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_rr_arbiter_if #(.DW(DW), .AW(AW)) p0 ();
    ram_rr_arbiter_if #(.DW(DW), .AW(AW)) p1 ();

    logic          init_done;
    logic          mem_WE;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    ram_rr_arbiter #(.DW(DW), .AW(AW), .INIT_VAL(INIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .port0        (p0),
        .port1        (p1),
        .init_done    (init_done),
        .mem_address  (mem_address),
        .mem_WE       (mem_WE),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Single-port synchronous RAM, registered read
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_WE) ram[mem_address] <= mem_data_in;
        mem_data_out <= ram[mem_address];
    end

    // Requester drivers
    logic          d_req  [2] = '{1'b0, 1'b0};
    logic          d_we   [2] = '{1'b0, 1'b0};
    logic          d_hold [2] = '{1'b0, 1'b0};
    logic [AW-1:0] d_addr [2] = '{'0, '0};
    logic [DW-1:0] d_wd   [2] = '{'0, '0};

    assign p0.req = d_req[0];  assign p0.we = d_we[0];
    assign p0.addr = d_addr[0]; assign p0.wdata = d_wd[0];
    assign p1.req = d_req[1];  assign p1.we = d_we[1];
    assign p1.addr = d_addr[1]; assign p1.wdata = d_wd[1];

    // Reference model: memory image, outstanding reads, availability time
    typedef struct { int port; int due; logic [DW-1:0] data; } rd_t;
    rd_t           q [$];
    logic [DW-1:0] m_mem   [DEPTH];
    logic [DW-1:0] m_rdata [2];
    int            m_free;
    int            m_last;
    int            cyc;
    int            gnt_cyc [2];
    int            rv_cyc  [2];
    int            gseq [$];
    int            gcyc [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_req[p] = 1'b1; d_we[p] = we; d_addr[p] = a; d_wd[p] = wd;
    endtask

    // One clock: predict from the model, advance, compare
    task automatic step();
        int            g;
        logic          gwe;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        logic          rv [2];
        rd_t           e;
        g = -1; gwe = 1'b0; ga = '0; gd = '0;
        if (cyc + 1 >= m_free && (d_req[0] || d_req[1])) begin
            if (d_req[0] && d_req[1]) g = (m_last == 0) ? 1 : 0;
            else                      g = d_req[0] ? 0 : 1;
            gwe = d_we[g]; ga = d_addr[g]; gd = d_wd[g];
            m_last = g;
            m_free = cyc + 1 + (gwe ? 2 : 3);
            if (gwe) m_mem[ga] = gd;
            else begin
                e.port = g; e.due = cyc + 3; e.data = m_mem[ga];
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        cyc++;
        rv = '{1'b0, 1'b0};
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            rv[e.port] = 1'b1;
            m_rdata[e.port] = e.data;
        end
        chk("gnt0", p0.gnt, g == 0);
        chk("gnt1", p1.gnt, g == 1);
        chk("gnt_onehot", p0.gnt & p1.gnt, 0);
        chk("init_done", init_done, cyc > DEPTH);
        if (g >= 0) begin
            chk("grant_we", mem_WE, gwe);
            chk("grant_addr", mem_address, ga);
            chk("grant_din", mem_data_in, gd);
            gnt_cyc[g] = cyc;
            gseq.push_back(g);
            gcyc.push_back(cyc);
            if (!d_hold[g]) d_req[g] = 1'b0;
        end else if (cyc >= 1 && cyc <= DEPTH) begin
            chk("sweep_we", mem_WE, 1);
            chk("sweep_addr", mem_address, cyc - 1);
            chk("sweep_din", mem_data_in, INIT);
        end else begin
            chk("idle_we", mem_WE, 0);
        end
        chk("rvalid0", p0.rvalid, rv[0]);
        chk("rvalid1", p1.rvalid, rv[1]);
        chk("rdata0", p0.rdata, m_rdata[0]);
        chk("rdata1", p1.rdata, m_rdata[1]);
        if (p0.rvalid) rv_cyc[0] = cyc;
        if (p1.rvalid) rv_cyc[1] = cyc;
    endtask

    // Run until no request, no outstanding read and the RAM is free
    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((d_req[0] || d_req[1] || q.size() > 0 || cyc + 1 < m_free) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", n < maxc, 1);
    endtask

    // Assert reset between edges, check async clear, hold one edge, release
    task automatic do_reset();
        rst = 1'b1; #1;
        chk("rst_we", mem_WE, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_gnt", {p0.gnt, p1.gnt}, 0);
        chk("rst_rvalid", {p0.rvalid, p1.rvalid}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_din", mem_data_in, 0);
        chk("rst_rdata", {p0.rdata, p1.rdata}, 0);
        @(posedge clk); #1;
        chk("rst_no_rvalid", {p0.rvalid, p1.rvalid}, 0);
        rst = 1'b0;
        cyc = 0;
        m_free = DEPTH + 2;
        m_last = 1;
        q.delete();
        m_rdata = '{'0, '0};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
    endtask

    initial begin
        int g0;
        #2;
        do_reset();

        // Port 1 read requested during init: granted on the first IDLE edge
        start(1, 1'b0, 2'd0, 4'h0);
        drain(40);
        chk("init_gnt1_cycle", gnt_cyc[1], DEPTH + 2);
        chk("init_rd_addr0", p1.rdata, 0);

        // Read of a freshly cleared location
        start(0, 1'b0, 2'd2, 4'h0);
        drain(20);
        chk("rd_addr2_cleared", p0.rdata, 0);

        // Write then read back on port 0
        start(0, 1'b1, 2'd1, 4'hA);
        drain(20);
        start(0, 1'b0, 2'd1, 4'h0);
        drain(20);
        chk("wr_rd_data", p0.rdata, 4'hA);
        chk("rd_latency", rv_cyc[0] - gnt_cyc[0], 2);
        chk("rdata1_held", p1.rdata, 0);

        // Continuous contention: grants alternate every 2 cycles
        gseq.delete(); gcyc.delete();
        d_hold = '{1'b1, 1'b1};
        start(0, 1'b1, 2'd0, 4'h3);
        start(1, 1'b1, 2'd3, 4'h5);
        repeat (8) step();
        d_hold = '{1'b0, 1'b0};
        drain(20);
        for (int i = 1; i < 4; i++) begin
            chk("contend_alt", gseq[i] != gseq[i-1], 1);
            chk("contend_gap", gcyc[i] - gcyc[i-1], 2);
        end
        start(0, 1'b0, 2'd0, 4'h0);
        drain(20);
        chk("contend_rb0", p0.rdata, 4'h3);
        start(1, 1'b0, 2'd3, 4'h0);
        drain(20);
        chk("contend_rb3", p1.rdata, 4'h5);

        // After a port-0 grant, a tie goes to port 1, port 0 follows 3 cycles later
        start(0, 1'b1, 2'd2, 4'h7);
        step();
        g0 = gnt_cyc[0];
        start(1, 1'b0, 2'd3, 4'h0);
        start(0, 1'b1, 2'd1, 4'h9);
        drain(20);
        chk("rr_p1_first", gnt_cyc[1] - g0, 2);
        chk("rr_p0_after", gnt_cyc[0] - gnt_cyc[1], 3);
        chk("rr_rdata1", p1.rdata, 4'h5);

        // Reset while a read is in RESP: op dropped, RAM re-cleared
        start(0, 1'b1, 2'd2, 4'hF);
        drain(20);
        start(0, 1'b0, 2'd2, 4'h0);
        step();
        step();
        do_reset();
        drain(20);
        start(0, 1'b0, 2'd2, 4'h0);
        drain(20);
        chk("post_rst_rd", p0.rdata, 0);

        // Randomized traffic from both ports
        repeat (400) begin
            for (int p = 0; p < 2; p++) begin
                if (!d_req[p] && $urandom_range(2) == 0)
                    start(p, 1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)),
                          DW'($urandom_range(15)));
            end
            step();
        end
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous RAM (rw_4x4_sync style) between two requesters.
- After reset it clears every RAM location to INIT_VAL, then serves read/write requests from port 0 and port 1 using a req/gnt handshake. Read data returns on a per-port rvalid pulse.
- Sits between client logic and the RAM instance. It drives the RAM address, write-enable and data-in pins and samples the RAM's data-out pin.

Parameters:
- DW, 4, data width.
- AW, 2, address width; depth = 2**AW.
- INIT_VAL, 0, value written to every location during init.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- req0  input  1  port 0 request; held until gnt0 is seen
- we0  input  1  port 0 op: 1=write, 0=read; stable while req0
- addr0  input  AW  port 0 address; stable while req0
- wdata0  input  DW  port 0 write data; stable while req0
- gnt0  output  1  one-cycle grant pulse to port 0
- rvalid0  output  1  one-cycle read-data-valid pulse to port 0
- rdata0  output  DW  port 0 read data; holds its value between reads
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
- init_done  output  1  high once the init sweep has completed
- mem_address  output  AW  to RAM address
- mem_WE  output  1  to RAM WE
- mem_data_in  output  DW  to RAM data_in
- mem_data_out  input  DW  from RAM data_out; valid one clock edge after the address is sampled

Behaviour:
- All outputs are registered.
- On rst, asynchronously:
  - state=INIT, init counter=0, last_grant=1 (so port 0 wins the first tie).
  - gnt0, gnt1, rvalid0, rvalid1, mem_WE, init_done, mem_address, mem_data_in, rdata0 and rdata1 all go to 0.
- INIT state:
  - Edges 1..2**AW after rst release drive mem_WE=1, mem_address=counter (0,1,2,3), mem_data_in=INIT_VAL.
  - On edge 2**AW+1: mem_WE=0, init_done=1, state goes to IDLE.
  - Requests are ignored during INIT: no gnt is issued and the requests stay pending.
- IDLE state, no request: mem_WE=0 and the state stays IDLE.
- IDLE state, one request pending: that port is granted.
- IDLE state, both requests pending: the port not equal to last_grant is granted.
- On the granting edge:
  - gntX is 1 for one cycle.
  - mem_address, mem_WE and mem_data_in are loaded from weX, addrX and wdataX.
  - last_grant=X and state goes to ISSUE.
  - Only one gnt can be high in any cycle.
- ISSUE state (RAM samples the op at the end of this cycle):
  - Next edge: mem_WE=0.
  - A write returns to IDLE.
  - A read goes to RESP and remembers the owner port.
- RESP state: mem_data_out is valid. On the next edge rdataX=mem_data_out, rvalidX=1 for one cycle, and state goes to IDLE.
- Latency:
  - A write occupies 2 cycles (grant to next grant possible 2 cycles later).
  - A read occupies 3 cycles; rvalidX is high exactly 2 cycles after gntX is high.
- Requester handshake: the requester samples gnt at the clock edge and must drop req (or present a new op) after that edge. req still high in the first IDLE cycle after gnt is treated as a new request.
- Back-to-back: a port may be granted consecutively while the other port is idle. Under continuous contention, grants alternate strictly.
- Other outputs: the non-owner port's rvalid stays 0, and its rdata holds its value.
- Address wrap: the init counter covers 0..2**AW-1 exactly, then stops; no wrap beyond.
- rst asserted mid-operation (ISSUE or RESP):
  - The outstanding op is dropped, with no rvalid.
  - mem_WE goes to 0 immediately and init restarts from address 0.
  - init_done drops to 0.

Test Plan:
- Release rst, DW=4 -> mem_WE=1 for 4 cycles with mem_address 0,1,2,3 and mem_data_in=0; init_done=1 on the 5th edge; a port 0 read of addr 2 returns rdata0=0.
- Port 0 writes addr1=4'hA, then port 0 reads addr1 -> gnt0 pulses twice; rvalid0=1 exactly 2 cycles after the second gnt0 with rdata0=4'hA; rvalid1 stays 0 and rdata1 stays 0.
- req0 and req1 held high continuously from init_done (port 0 writes 4'h3 to addr0, port 1 writes 4'h5 to addr3) -> grant order 0,1,0,1, one grant every 2 cycles, never both gnt high; readback gives addr0=3 and addr3=5.
- req1 asserted (read addr0) during INIT -> no gnt1 before init_done; gnt1 on the first IDLE edge; rvalid1 with rdata1=0.
- Write addr2=4'hF, start a read of addr2, assert rst during RESP -> no rvalid0, mem_WE=0 at once, re-init sweep from address 0; a subsequent read of addr2 returns 0.
- Port 1 reads addr3 while port 0 requests a write in the same cycle after a port-0 grant (last_grant=0) -> port 1 is granted first; port 0 is granted 3 cycles later; rvalid1 is not affected by the port 0 write.
